// File: rtl/fdivsqrt_int_postproc_if.sv
// Handshake and data bundle between the div/sqrt iterator and its integer back end.
interface fdivsqrt_int_postproc_if #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned DIVb    = 64,
    parameter int unsigned DIVBLEN = 7
);
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [DIVb:0]      U;
    logic [DIVb+3:0]    W;
    logic [DIVb+3:0]    D;
    logic [DIVBLEN-1:0] IntNormShift;
    logic               RemOp;
    logic               AltB;
    logic               BZero;
    logic               As;
    logic               Bs;
    logic               W64;
    logic [XLEN-1:0]    A;
    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    IntDivResult;

    // Producer / consumer side
    modport master (
        output flush, in_valid, U, W, D, IntNormShift, RemOp, AltB, BZero, As, Bs, W64, A,
        output out_ready,
        input  in_ready, out_valid, IntDivResult
    );

    // Post-processing block side
    modport slave (
        input  flush, in_valid, U, W, D, IntNormShift, RemOp, AltB, BZero, As, Bs, W64, A,
        input  out_ready,
        output in_ready, out_valid, IntDivResult
    );
endinterface

// File: rtl/fdivsqrt_int_postproc.sv
// Integer back end of the divide/square-root unit: residual correction, multi-cycle
// right shift to integer alignment, sign/W64 fix-up and result handshake.
module fdivsqrt_int_postproc #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned DIVb    = 64,
    parameter int unsigned DIVBLEN = 7,
    parameter int unsigned SHSTEP  = 16
) (
    input logic clk,
    input logic reset,
    fdivsqrt_int_postproc_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StShift, StSign, StDone} state_e;

    localparam logic [DIVBLEN-1:0] ShStep = DIVBLEN'(SHSTEP);

    state_e             state_q, state_d;
    logic [DIVb+3:0]    pre_q, pre_d;
    logic [DIVBLEN-1:0] rem_q, rem_d;
    logic               rem_op_q, rem_op_d;
    logic               as_q, as_d;
    logic               bs_q, bs_d;
    logic               w64_q, w64_d;
    logic [XLEN-1:0]    result_q, result_d;

    logic               accept;
    logic               w_neg;
    logic [DIVb:0]      u_dec;
    logic [DIVBLEN-1:0] shamt;
    logic               negate;
    logic [XLEN-1:0]    sign_r;
    logic [XLEN-1:0]    special_r;

    // Replicate bit 31 into the upper half for word operations.
    function automatic logic [XLEN-1:0] w64_ext(input logic [XLEN-1:0] r, input logic w64);
        logic [XLEN-1:0] o;
        o = r;
        if (w64) begin
            for (int unsigned i = 32; i < XLEN; i++) begin
                o[i] = r[31];
            end
        end
        return o;
    endfunction

    assign bus.in_ready     = (state_q == StIdle);
    assign bus.out_valid    = (state_q == StDone);
    assign bus.IntDivResult = result_q;

    // flush wins over accept so a flushed cycle never disturbs held state
    assign accept    = bus.in_valid & (state_q == StIdle) & ~bus.flush;
    assign w_neg     = bus.W[DIVb+3];
    assign u_dec     = bus.U - (DIVb+1)'(1);
    assign shamt     = (rem_q < ShStep) ? rem_q : ShStep;
    assign negate    = rem_op_q ? as_q : (as_q ^ bs_q);
    assign sign_r    = negate ? (~pre_q[XLEN-1:0] + XLEN'(1)) : pre_q[XLEN-1:0];
    assign special_r = bus.RemOp ? bus.A : (bus.BZero ? '1 : '0);

    // Next-state and datapath updates for the four-state sequencer
    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        rem_d    = rem_q;
        rem_op_d = rem_op_q;
        as_d     = as_q;
        bs_d     = bs_q;
        w64_d    = w64_q;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    rem_op_d = bus.RemOp;
                    as_d     = bus.As;
                    bs_d     = bus.Bs;
                    w64_d    = bus.W64;
                    if (bus.BZero | bus.AltB) begin
                        result_d = w64_ext(special_r, bus.W64);
                        state_d  = StDone;
                    end else begin
                        if (bus.RemOp) begin
                            pre_d = w_neg ? (bus.W + bus.D) : bus.W;
                        end else begin
                            pre_d = w_neg ? {3'b000, u_dec} : {3'b000, bus.U};
                        end
                        rem_d   = bus.IntNormShift;
                        state_d = (bus.IntNormShift != '0) ? StShift : StSign;
                    end
                end
            end
            StShift: begin
                pre_d = pre_q >> shamt;
                rem_d = rem_q - shamt;
                if (rem_d == '0) begin
                    state_d = StSign;
                end
            end
            StSign: begin
                result_d = w64_ext(sign_r, w64_q);
                state_d  = StDone;
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (bus.flush) begin
            state_d = StIdle;
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            pre_q    <= '0;
            rem_q    <= '0;
            rem_op_q <= 1'b0;
            as_q     <= 1'b0;
            bs_q     <= 1'b0;
            w64_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            rem_q    <= rem_d;
            rem_op_q <= rem_op_d;
            as_q     <= as_d;
            bs_q     <= bs_d;
            w64_q    <= w64_d;
            result_q <= result_d;
        end
    end
endmodule

// File: tb/tb_fdivsqrt_int_postproc.sv
// Directed bench for fdivsqrt_int_postproc with an expected-result queue.
module tb_fdivsqrt_int_postproc;
    localparam int unsigned XLEN    = 64;
    localparam int unsigned DIVb    = 64;
    localparam int unsigned DIVBLEN = 7;
    localparam int unsigned SHSTEP  = 16;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    logic [XLEN-1:0] exp_q[$];
    int   lat_q[$];

    fdivsqrt_int_postproc_if #(.XLEN(XLEN), .DIVb(DIVb), .DIVBLEN(DIVBLEN)) bus ();

    fdivsqrt_int_postproc #(
        .XLEN(XLEN), .DIVb(DIVb), .DIVBLEN(DIVBLEN), .SHSTEP(SHSTEP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one transaction, push its expected result and latency.
    task automatic drive(input logic [DIVb:0] u, input logic [DIVb+3:0] w,
                         input logic [DIVb+3:0] d, input int s, input logic rem_op,
                         input logic altb, input logic bzero, input logic as_i,
                         input logic bs_i, input logic w64, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] exp_res, input logic push);
        bus.U            = u;
        bus.W            = w;
        bus.D            = d;
        bus.IntNormShift = DIVBLEN'(s);
        bus.RemOp        = rem_op;
        bus.AltB         = altb;
        bus.BZero        = bzero;
        bus.As           = as_i;
        bus.Bs           = bs_i;
        bus.W64          = w64;
        bus.A            = a;
        bus.in_valid     = 1'b1;
        if (push) begin
            exp_q.push_back(exp_res);
            lat_q.push_back((altb | bzero) ? 1 : ((s + SHSTEP - 1) / SHSTEP + 2));
        end
        step();
        bus.in_valid = 1'b0;
        bus.U        = '1;
        bus.W        = '1;
        bus.A        = '1;
    endtask

    // Wait (bounded) for out_valid, compare latency and result, then retire it.
    task automatic collect(input string tag, input int hold);
        int cyc;
        logic [XLEN-1:0] e;
        int el;
        cyc = 1;
        while (bus.out_valid !== 1'b1 && cyc < 200) begin
            step();
            cyc++;
        end
        e  = exp_q.pop_front();
        el = lat_q.pop_front();
        check({tag, "_lat"}, 128'(cyc), 128'(el));
        check({tag, "_res"}, 128'(bus.IntDivResult), 128'(e));
        for (int i = 0; i < hold; i++) begin
            step();
            check({tag, "_hold_valid"}, 128'(bus.out_valid), 128'(1));
            check({tag, "_hold_res"}, 128'(bus.IntDivResult), 128'(e));
            check({tag, "_hold_inrdy"}, 128'(bus.in_ready), 128'(0));
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({tag, "_retire"}, 128'(bus.out_valid), 128'(0));
    endtask

    initial begin
        logic [DIVb+3:0] ones68;
        errors = 0;
        checks = 0;
        ones68 = '1;
        reset = 1'b0;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.U = '0; bus.W = '0; bus.D = '0; bus.IntNormShift = '0;
        bus.RemOp = 0; bus.AltB = 0; bus.BZero = 0; bus.As = 0; bus.Bs = 0; bus.W64 = 0;
        bus.A = '0;
        step();
        step();
        check("rst_valid", 128'(bus.out_valid), 128'(0));
        check("rst_res", 128'(bus.IntDivResult), 128'(0));
        check("rst_inrdy", 128'(bus.in_ready), 128'(1));
        reset = 1'b1;
        step();

        // Signed quotient, three shift cycles, held under backpressure for 10 cycles
        drive(65'(7) << 40, '0, '0, 40, 0, 0, 0, 1, 0, 0, '0, 64'hFFFF_FFFF_FFFF_FFF9, 1);
        collect("q_neg", 10);
        // Negative residual corrections
        drive(65'(6) << 40, ones68, 68'(2), 40, 0, 0, 0, 0, 0, 0, '0, 64'd5, 1);
        collect("q_wneg", 0);
        drive(65'(6) << 40, ones68, 68'(2), 0, 1, 0, 0, 0, 0, 0, '0, 64'd1, 1);
        collect("r_wneg", 0);
        // W64 remainder sign extension
        drive('0, 68'h8000_0000, '0, 0, 1, 0, 0, 0, 0, 1, '0, 64'hFFFF_FFFF_8000_0000, 1);
        collect("r_w64", 0);
        // Special cases
        drive('0, '0, '0, 5, 0, 0, 1, 0, 0, 0, 64'h55, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        collect("bzero_q", 0);
        drive('0, '0, '0, 5, 1, 1, 1, 0, 0, 0, 64'h1234, 64'h1234, 1);
        collect("bzero_r", 0);
        drive('0, '0, '0, 5, 0, 1, 0, 1, 1, 0, 64'h1234, 64'h0, 1);
        collect("altb_q", 0);
        // Shift beyond the datapath clears the result; signed remainder negation
        drive('1, '0, '0, 68, 0, 0, 0, 0, 0, 0, '0, 64'h0, 1);
        collect("over", 0);
        drive('0, 68'h3 << 20, '0, 20, 1, 0, 0, 1, 0, 0, '0, 64'hFFFF_FFFF_FFFF_FFFD, 1);
        collect("r_sgn", 0);

        // Flush during SHIFT
        drive(65'(7) << 40, '0, '0, 40, 0, 0, 0, 0, 0, 0, '0, '0, 0);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("flush_valid", 128'(bus.out_valid), 128'(0));
        check("flush_inrdy", 128'(bus.in_ready), 128'(1));
        check("flush_res", 128'(bus.IntDivResult), 128'(64'hFFFF_FFFF_FFFF_FFFD));
        for (int i = 0; i < 6; i++) step();
        check("flush_quiet", 128'(bus.out_valid), 128'(0));

        // Reset during SHIFT
        drive(65'(7) << 40, '0, '0, 40, 0, 0, 0, 0, 0, 0, '0, '0, 0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("mrst_valid", 128'(bus.out_valid), 128'(0));
        check("mrst_res", 128'(bus.IntDivResult), 128'(0));
        check("mrst_inrdy", 128'(bus.in_ready), 128'(1));
        drive(65'(9) << 16, '0, '0, 16, 0, 0, 0, 0, 0, 0, '0, 64'd9, 1);
        collect("post_rst", 0);

        check("sb_empty", 128'(exp_q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
